// File: rtl/cursor_controller.sv
// Cursor position generator: synchronised, debounced buttons drive per-axis
// press/hold/repeat/accelerate FSMs that step a clamped or wrapped position.
//
// Axis FSM states (evaluated once per tick):
//   state     | meaning
//   ST_IDLE   | no direction held, no motion
//   ST_HOLD   | single step applied, waiting REPEAT_DELAY ticks
//   ST_REPEAT | stepping by 1 each tick for ACCEL_DELAY ticks
//   ST_FAST   | stepping by FAST_STEP each tick
module cursor_controller #(
   parameter int H_RES          = 640,
   parameter int V_RES          = 480,
   parameter int X_W            = 10,
   parameter int Y_W            = 9,
   parameter int TICK_CYCLES    = 1048576,
   parameter int DEBOUNCE_TICKS = 2,
   parameter int REPEAT_DELAY   = 30,
   parameter int ACCEL_DELAY    = 20,
   parameter int FAST_STEP      = 8,
   parameter int WRAP           = 0
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_btn_u,
   input  logic           i_btn_d,
   input  logic           i_btn_l,
   input  logic           i_btn_r,
   input  logic           i_btn_c,
   output logic [X_W-1:0] o_cursor_x,
   output logic [Y_W-1:0] o_cursor_y,
   output logic           o_moved
);

   localparam int TC_W   = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam int DB_W   = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam int HC_MAX = (REPEAT_DELAY > ACCEL_DELAY) ? REPEAT_DELAY : ACCEL_DELAY;
   localparam int HC_W   = $clog2(HC_MAX + 1);

   localparam logic [TC_W-1:0] TC_LOAD = TC_W'(TICK_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
   localparam logic [HC_W-1:0] RD_C    = HC_W'(REPEAT_DELAY);
   localparam logic [HC_W-1:0] AD_C    = HC_W'(ACCEL_DELAY);

   localparam logic [X_W-1:0] X_MID   = X_W'(H_RES / 2);
   localparam logic [Y_W-1:0] Y_MID   = Y_W'(V_RES / 2);
   localparam logic [X_W-1:0] X_MAX   = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_MAX   = Y_W'(V_RES - 1);
   localparam logic [X_W:0]   H_RES_E = (X_W + 1)'(H_RES);
   localparam logic [Y_W:0]   V_RES_E = (Y_W + 1)'(V_RES);
   localparam logic [X_W:0]   FAST_X  = (X_W + 1)'(FAST_STEP);
   localparam logic [Y_W:0]   FAST_Y  = (Y_W + 1)'(FAST_STEP);

   localparam int B_U = 0;
   localparam int B_D = 1;
   localparam int B_L = 2;
   localparam int B_R = 3;
   localparam int B_C = 4;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_INC  = 2'b01;
   localparam logic [1:0] DIR_DEC  = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT, ST_FAST} axis_state_t;

   logic [4:0]      btn_raw, sync_meta, sync_btn, filt_btn;
   logic [DB_W-1:0] db_cnt [5];
   logic [TC_W-1:0] tick_cnt;
   logic            tick;

   axis_state_t     state   [2];
   logic [1:0]      dir_lat [2];
   logic [1:0]      dir_now [2];
   logic [HC_W-1:0] hcnt    [2];
   logic [HC_W-1:0] hcnt_nx [2];
   logic [1:0]      mv_dir  [2];
   logic            mv_fast [2];
   logic            c_prev, centre_pend, pos_upd;

   logic [X_W:0]    x_ext, x_step, x_sum, x_dif, x_wup, x_wdn;
   logic [Y_W:0]    y_ext, y_step, y_sum, y_dif, y_wup, y_wdn;
   logic [X_W-1:0]  nx;
   logic [Y_W-1:0]  ny;

   assign btn_raw = {i_btn_c, i_btn_r, i_btn_l, i_btn_d, i_btn_u};
   assign tick    = (tick_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_meta <= '0;
         sync_btn  <= '0;
         tick_cnt  <= TC_LOAD;
      end else begin
         sync_meta <= btn_raw;
         sync_btn  <= sync_meta;
         tick_cnt  <= tick ? TC_LOAD : tick_cnt - 1'b1;
      end
   end

   // A button flips only after DEBOUNCE_TICKS consecutive disagreeing tick samples
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         filt_btn <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else if (tick) begin
         for (int i = 0; i < 5; i++) begin
            if (sync_btn[i] == filt_btn[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               filt_btn[i] <= ~filt_btn[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      dir_now[0] = filt_btn[B_R] ? DIR_INC : (filt_btn[B_L] ? DIR_DEC : DIR_NONE);
      dir_now[1] = filt_btn[B_U] ? DIR_DEC : (filt_btn[B_D] ? DIR_INC : DIR_NONE);
      for (int a = 0; a < 2; a++) hcnt_nx[a] = hcnt[a] + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         c_prev      <= 1'b0;
         centre_pend <= 1'b0;
         pos_upd     <= 1'b0;
         for (int a = 0; a < 2; a++) begin
            state[a]   <= ST_IDLE;
            dir_lat[a] <= DIR_NONE;
            hcnt[a]    <= '0;
            mv_dir[a]  <= DIR_NONE;
            mv_fast[a] <= 1'b0;
         end
      end else begin
         pos_upd <= tick;
         if (tick) begin
            c_prev      <= filt_btn[B_C];
            centre_pend <= filt_btn[B_C] & ~c_prev;
            for (int a = 0; a < 2; a++) begin
               mv_dir[a]  <= DIR_NONE;
               mv_fast[a] <= 1'b0;
               if (dir_now[a] == DIR_NONE) begin
                  state[a] <= ST_IDLE;
               end else if (state[a] == ST_IDLE || dir_now[a] != dir_lat[a]) begin
                  state[a]   <= ST_HOLD;
                  hcnt[a]    <= '0;
                  dir_lat[a] <= dir_now[a];
                  mv_dir[a]  <= dir_now[a];
               end else begin
                  case (state[a])
                     ST_HOLD: begin
                        if (hcnt_nx[a] == RD_C) begin
                           mv_dir[a] <= dir_now[a];
                           state[a]  <= ST_REPEAT;
                           hcnt[a]   <= '0;
                        end else begin
                           hcnt[a] <= hcnt_nx[a];
                        end
                     end
                     ST_REPEAT: begin
                        mv_dir[a] <= dir_now[a];
                        if (hcnt_nx[a] == AD_C) begin
                           mv_fast[a] <= 1'b1;
                           state[a]   <= ST_FAST;
                        end else begin
                           hcnt[a] <= hcnt_nx[a];
                        end
                     end
                     ST_FAST: begin
                        mv_dir[a]  <= dir_now[a];
                        mv_fast[a] <= 1'b1;
                     end
                     default: state[a] <= ST_IDLE;
                  endcase
               end
            end
         end
      end
   end

   // One extra bit of headroom keeps p+s and p+RES-s from overflowing
   always_comb begin
      x_ext  = {1'b0, o_cursor_x};
      x_step = mv_fast[0] ? FAST_X : (X_W + 1)'(1);
      x_sum  = x_ext + x_step;
      x_dif  = x_ext - x_step;
      x_wup  = x_sum - H_RES_E;
      x_wdn  = x_ext + H_RES_E - x_step;
      nx     = o_cursor_x;
      if (centre_pend) begin
         nx = X_MID;
      end else if (mv_dir[0] == DIR_INC) begin
         if (x_sum >= H_RES_E) nx = (WRAP != 0) ? X_W'(x_wup) : X_MAX;
         else                  nx = X_W'(x_sum);
      end else if (mv_dir[0] == DIR_DEC) begin
         if (x_ext < x_step) nx = (WRAP != 0) ? X_W'(x_wdn) : '0;
         else                nx = X_W'(x_dif);
      end
   end

   always_comb begin
      y_ext  = {1'b0, o_cursor_y};
      y_step = mv_fast[1] ? FAST_Y : (Y_W + 1)'(1);
      y_sum  = y_ext + y_step;
      y_dif  = y_ext - y_step;
      y_wup  = y_sum - V_RES_E;
      y_wdn  = y_ext + V_RES_E - y_step;
      ny     = o_cursor_y;
      if (centre_pend) begin
         ny = Y_MID;
      end else if (mv_dir[1] == DIR_INC) begin
         if (y_sum >= V_RES_E) ny = (WRAP != 0) ? Y_W'(y_wup) : Y_MAX;
         else                  ny = Y_W'(y_sum);
      end else if (mv_dir[1] == DIR_DEC) begin
         if (y_ext < y_step) ny = (WRAP != 0) ? Y_W'(y_wdn) : '0;
         else                ny = Y_W'(y_dif);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_cursor_x <= X_MID;
         o_cursor_y <= Y_MID;
         o_moved    <= 1'b0;
      end else if (pos_upd) begin
         o_cursor_x <= nx;
         o_cursor_y <= ny;
         o_moved    <= (nx != o_cursor_x) || (ny != o_cursor_y);
      end else begin
         o_moved <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench: a clamping and a wrapping instance share the same buttons
// so each scenario checks both edge behaviours against hand-derived positions.
module tb_cursor_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       bu, bd, bl, br, bc;
   logic [3:0] cx, wx;
   logic [2:0] cy, wy;
   logic       cm, wm;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   cursor_controller #(
      .H_RES(16), .V_RES(8), .X_W(4), .Y_W(3), .TICK_CYCLES(4), .DEBOUNCE_TICKS(2),
      .REPEAT_DELAY(3), .ACCEL_DELAY(2), .FAST_STEP(4), .WRAP(0)
   ) dut_c (
      .i_clk(clk), .i_rst(rst), .i_btn_u(bu), .i_btn_d(bd), .i_btn_l(bl),
      .i_btn_r(br), .i_btn_c(bc), .o_cursor_x(cx), .o_cursor_y(cy), .o_moved(cm)
   );

   cursor_controller #(
      .H_RES(16), .V_RES(8), .X_W(4), .Y_W(3), .TICK_CYCLES(4), .DEBOUNCE_TICKS(2),
      .REPEAT_DELAY(3), .ACCEL_DELAY(2), .FAST_STEP(4), .WRAP(1)
   ) dut_w (
      .i_clk(clk), .i_rst(rst), .i_btn_u(bu), .i_btn_d(bd), .i_btn_l(bl),
      .i_btn_r(br), .i_btn_c(bc), .o_cursor_x(wx), .o_cursor_y(wy), .o_moved(wm)
   );

   task automatic do_reset();
      rst = 1'b1;
      {bu, bd, bl, br, bc} = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for a pulse on the clamp (sel=0) or wrap (sel=1) instance; n=-1 on timeout
   task automatic wait_pulse(input bit sel, input int max_cycles, output int n);
      n = -1;
      for (int i = 1; i <= max_cycles && n < 0; i++) begin
         @(negedge clk);
         if ((sel ? wm : cm) === 1'b1) n = i;
      end
   endtask

   task automatic test_reset();
      int pulses;
      do_reset();
      total++; if (cx !== 4'd8) begin bad++; $display("FAIL reset_x got=%0d exp=8", cx); end
      total++; if (cy !== 3'd4) begin bad++; $display("FAIL reset_y got=%0d exp=4", cy); end
      total++; if (cm !== 1'b0) begin bad++; $display("FAIL reset_moved got=%b exp=0", cm); end
      total++; if (wx !== 4'd8) begin bad++; $display("FAIL reset_wrap_x got=%0d exp=8", wx); end
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cm === 1'b1 || wm === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
      total++; if (cx !== 4'd8 || cy !== 3'd4) begin
         bad++; $display("FAIL idle_pos got=%0d,%0d exp=8,4", cx, cy);
      end
   endtask

   task automatic test_hold_r();
      int n;
      int exp_x [4] = '{9, 10, 11, 15};
      int exp_n [4] = '{-2, 11, 3, 3};
      do_reset();
      br = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_pulse(1'b0, 40, n);
         total++;
         if (n < 0 || (exp_n[k] >= 0 && n != exp_n[k])) begin
            bad++; $display("FAIL hold_r_gap%0d got=%0d exp=%0d", k, n, exp_n[k]);
         end
         total++; if (cx !== exp_x[k][3:0]) begin bad++; $display("FAIL hold_r_x%0d got=%0d exp=%0d", k, cx, exp_x[k]); end
         total++; if (wx !== exp_x[k][3:0]) begin bad++; $display("FAIL hold_r_wx%0d got=%0d exp=%0d", k, wx, exp_x[k]); end
         total++; if (cy !== 3'd4) begin bad++; $display("FAIL hold_r_y%0d got=%0d exp=4", k, cy); end
         @(negedge clk);
         total++; if (cm !== 1'b0) begin bad++; $display("FAIL hold_r_width%0d got=%b exp=0", k, cm); end
      end
      wait_pulse(1'b1, 20, n);
      total++; if (n != 3) begin bad++; $display("FAIL hold_r_wrap_gap got=%0d exp=3", n); end
      total++; if (wx !== 4'd3) begin bad++; $display("FAIL hold_r_wrap_x got=%0d exp=3", wx); end
      total++; if (cm !== 1'b0 || cx !== 4'd15) begin
         bad++; $display("FAIL hold_r_clamp got=x%0d m%b exp=x15 m0", cx, cm);
      end
      wait_pulse(1'b0, 12, n);
      total++; if (n != -1) begin bad++; $display("FAIL hold_r_clamp_quiet got=%0d exp=-1", n); end
      br = 1'b0;
   endtask

   task automatic test_glitch_and_both();
      int n;
      do_reset();
      repeat (3) @(negedge clk);
      br = 1'b1;
      repeat (4) @(negedge clk);
      br = 1'b0;
      wait_pulse(1'b0, 40, n);
      total++; if (n != -1 || cx !== 4'd8) begin
         bad++; $display("FAIL glitch got=n%0d x%0d exp=n-1 x8", n, cx);
      end
      br = 1'b1;
      bl = 1'b1;
      wait_pulse(1'b0, 40, n);
      total++; if (n < 0 || cx !== 4'd9 || wx !== 4'd9) begin
         bad++; $display("FAIL r_and_l got=n%0d x%0d wx%0d exp=x9", n, cx, wx);
      end
      {br, bl} = '0;
   endtask

   task automatic test_centre_idle();
      int n;
      do_reset();
      bc = 1'b1;
      wait_pulse(1'b0, 40, n);
      total++; if (n != -1 || cx !== 4'd8 || cy !== 3'd4) begin
         bad++; $display("FAIL centre_idle got=n%0d x%0d y%0d exp=n-1 x8 y4", n, cx, cy);
      end
      bc = 1'b0;
   endtask

   task automatic test_hold_d_centre();
      int n;
      int exp_y [3] = '{5, 6, 7};
      do_reset();
      bd = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_pulse(1'b0, 40, n);
         total++; if (n < 0 || cy !== exp_y[k][2:0] || wy !== exp_y[k][2:0]) begin
            bad++; $display("FAIL hold_d_y%0d got=n%0d y%0d wy%0d exp=%0d", k, n, cy, wy, exp_y[k]);
         end
      end
      wait_pulse(1'b1, 20, n);
      total++; if (n != 4 || wy !== 3'd3 || cy !== 3'd7 || cm !== 1'b0) begin
         bad++; $display("FAIL hold_d_edge got=n%0d wy%0d y%0d m%b exp=n4 wy3 y7 m0", n, wy, cy, cm);
      end
      bc = 1'b1;
      wait_pulse(1'b0, 40, n);
      total++; if (n < 0 || cy !== 3'd4 || cx !== 4'd8 || wy !== 3'd4 || wx !== 4'd8) begin
         bad++; $display("FAIL centre got=n%0d x%0d y%0d wx%0d wy%0d exp=8,4", n, cx, cy, wx, wy);
      end
      wait_pulse(1'b0, 8, n);
      total++; if (n != 4 || cy !== 3'd7 || wy !== 3'd0) begin
         bad++; $display("FAIL after_centre got=n%0d y%0d wy%0d exp=n4 y7 wy0", n, cy, wy);
      end
      {bd, bc} = '0;
   endtask

   task automatic test_hold_l_wrap();
      int n;
      int exp_c [5] = '{7, 6, 5, 1, 0};
      int exp_w [5] = '{7, 6, 5, 1, 13};
      do_reset();
      bl = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_pulse(1'b0, 40, n);
         total++; if (n < 0 || cx !== exp_c[k][3:0] || wx !== exp_w[k][3:0]) begin
            bad++; $display("FAIL hold_l_%0d got=n%0d x%0d wx%0d exp=%0d,%0d", k, n, cx, wx, exp_c[k], exp_w[k]);
         end
      end
      wait_pulse(1'b1, 8, n);
      total++; if (n != 4 || wx !== 4'd9 || cx !== 4'd0 || cm !== 1'b0) begin
         bad++; $display("FAIL hold_l_next got=n%0d wx%0d x%0d m%b exp=n4 wx9 x0 m0", n, wx, cx, cm);
      end
      bl = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      br = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_pulse(1'b0, 40, n);
         total++; if (n < 0) begin bad++; $display("FAIL mid_pulse%0d got=timeout exp=pulse", k); end
      end
      total++; if (cx !== 4'd15) begin bad++; $display("FAIL mid_fast_x got=%0d exp=15", cx); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (cx !== 4'd8 || wx !== 4'd8 || cm !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=x%0d wx%0d m%b exp=x8 wx8 m0", cx, wx, cm);
      end
      wait_pulse(1'b0, 40, n);
      total++; if (n < 8 || n > 16 || cx !== 4'd9 || wx !== 4'd9) begin
         bad++; $display("FAIL mid_repress got=n%0d x%0d wx%0d exp=n8..16 x9", n, cx, wx);
      end
      br = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {bu, bd, bl, br, bc} = '0;
      test_reset();
      test_hold_r();
      test_glitch_and_both();
      test_centre_idle();
      test_hold_d_centre();
      test_hold_l_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
